// File: rtl/apb_ram_arbiter.sv
// apb_ram_arbiter: round-robin sharing of one single-port 32-bit RAM between an APB slave and a DMA requester.
// Optional macro APB_RAM_ERR_EN: misaligned or out-of-range APB addresses get PSLVERR instead of a RAM access.
module apb_ram_arbiter #(
   parameter int ADDR_W = 10
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [31:0]       PADDR,
   input  logic [31:0]       PWDATA,
   output logic [31:0]       PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   input  logic              dma_req,
   input  logic              dma_wen,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [31:0]       dma_wdata,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [31:0]       dma_rdata,
   output logic              ram_en,
   output logic              ram_wen,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);
   typedef enum logic {IDLE, APB_RESP} state_t;
   state_t state, state_nx;
   logic last_dma, rd_q, err_q, dv_q, apb_req, bad, apb_gnt;
   logic [31:0] drd_q;
   assign apb_req = PSEL & PENABLE & (state == IDLE);
`ifdef APB_RAM_ERR_EN
   assign bad = (PADDR[1:0] != 2'b0) | (PADDR[31:ADDR_W+2] != '0);
`else
   logic unused_paddr;
   assign unused_paddr = ^{PADDR[31:ADDR_W+2], PADDR[1:0]};
   assign bad = 1'b0;
`endif
   // Arbitration (APB wins a tie unless it won last), RAM pin mux and next state; nothing is granted in reset
   always_comb begin
      apb_gnt = nRST & apb_req & ~bad & (~dma_req | last_dma);
      dma_gnt = nRST & dma_req & ~apb_gnt;
      ram_en = apb_gnt | dma_gnt;
      ram_wen = apb_gnt ? PWRITE : dma_gnt & dma_wen;
      ram_addr = apb_gnt ? PADDR[ADDR_W+1:2] : dma_gnt ? dma_addr : '0;
      ram_wdata = apb_gnt ? PWDATA : dma_gnt ? dma_wdata : '0;
      state_nx = (state == IDLE && (apb_gnt || (apb_req && bad))) ? APB_RESP : IDLE;
   end
   // State, grant history, response flags and held DMA read data
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state <= IDLE;
         last_dma <= 1'b1;
         rd_q <= 1'b0;
         err_q <= 1'b0;
         dv_q <= 1'b0;
         drd_q <= '0;
      end else begin
         state <= state_nx;
         if (ram_en) last_dma <= dma_gnt;
         rd_q <= apb_gnt & ~PWRITE;
         err_q <= apb_req & bad;
         dv_q <= dma_gnt & ~dma_wen;
         if (dv_q) drd_q <= ram_rdata;
      end
   end
   assign PREADY = state == APB_RESP;
   assign PRDATA = (PREADY & rd_q) ? ram_rdata : '0;
   assign PSLVERR = PREADY & err_q;
   assign dma_rvalid = dv_q;
   assign dma_rdata = dv_q ? ram_rdata : drd_q;
endmodule

// File: tb/tb_apb_ram_arbiter.sv
// tb_apb_ram_arbiter: vector table, corner sequences and randomized traffic against a shadow-memory model.
module tb_apb_ram_arbiter;
   logic CLK = 1'b0, nRST, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
   logic [31:0] PADDR, PWDATA, PRDATA;
   logic dma_req, dma_wen, dma_gnt, dma_rvalid, ram_en, ram_wen;
   logic [9:0] dma_addr, ram_addr;
   logic [31:0] dma_wdata, dma_rdata, ram_wdata, ram_rdata;
   logic [31:0] mem [1024] = '{default: 32'h0};
   logic [31:0] sh [1024] = '{default: 32'h0};
   int pass = 0, total = 0;
   typedef struct {
      logic psel, pen, pwr;
      logic [31:0] paddr, pwdata;
      logic dreq, dwen;
      logic [9:0] daddr;
      logic [31:0] dwdata;
      logic en, wen;
      logic [9:0] addr;
      logic [31:0] wdata;
      logic rdy;
      logic [31:0] prd;
      logic gnt, rv;
      logic [31:0] drd;
   } vec_t;
   vec_t v [14];
   logic awin, dwin, ml, mr, mw, mdv, ddrop;
   logic [31:0] mrx, mdx;
   logic [9:0] aw;
   int ast, ac, dw;

   apb_ram_arbiter #(.ADDR_W(10)) dut (
      .CLK(CLK), .nRST(nRST), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .dma_req(dma_req),
      .dma_wen(dma_wen), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
      .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .ram_en(ram_en), .ram_wen(ram_wen),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 CLK = ~CLK;

   // Single-port synchronous RAM with one-cycle read latency
   always @(posedge CLK) begin
      if (ram_en && ram_wen) mem[ram_addr] <= ram_wdata;
      if (ram_en && !ram_wen) ram_rdata <= mem[ram_addr];
   end

   task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
      total++;
      if (a === e) pass++;
      else $display("FAIL %s: got %h expected %h", n, a, e);
   endtask

   task automatic sa(input logic s, input logic e, input logic w, input logic [31:0] a, input logic [31:0] d);
      PSEL = s; PENABLE = e; PWRITE = w; PADDR = a; PWDATA = d;
   endtask

   task automatic sd(input logic r, input logic w, input logic [9:0] a, input logic [31:0] d);
      dma_req = r; dma_wen = w; dma_addr = a; dma_wdata = d;
   endtask

   task automatic step;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      v[0]  = '{'1, '0, '1, 32'h10, 32'hDEADBEEF, '0, '0, '0, 32'h0,        '0, '0, '0, 32'h0,        '0, 32'h0,        '0, '0, 32'h0};
      v[1]  = '{'1, '1, '1, 32'h10, 32'hDEADBEEF, '0, '0, '0, 32'h0,        '1, '1, 10'd4, 32'hDEADBEEF, '0, 32'h0,        '0, '0, 32'h0};
      v[2]  = '{'1, '1, '1, 32'h10, 32'hDEADBEEF, '0, '0, '0, 32'h0,        '0, '0, '0, 32'h0,        '1, 32'h0,        '0, '0, 32'h0};
      v[3]  = '{'1, '0, '0, 32'h10, 32'h0,        '0, '0, '0, 32'h0,        '0, '0, '0, 32'h0,        '0, 32'h0,        '0, '0, 32'h0};
      v[4]  = '{'1, '1, '0, 32'h10, 32'h0,        '0, '0, '0, 32'h0,        '1, '0, 10'd4, 32'h0,     '0, 32'h0,        '0, '0, 32'h0};
      v[5]  = '{'1, '1, '0, 32'h10, 32'h0,        '0, '0, '0, 32'h0,        '0, '0, '0, 32'h0,        '1, 32'hDEADBEEF, '0, '0, 32'h0};
      v[6]  = '{'0, '0, '0, 32'h0,  32'h0,        '1, '1, 10'd7, 32'h12345678, '1, '1, 10'd7, 32'h12345678, '0, 32'h0,     '1, '0, 32'h0};
      v[7]  = '{'0, '0, '0, 32'h0,  32'h0,        '1, '0, 10'd7, 32'h0,     '1, '0, 10'd7, 32'h0,     '0, 32'h0,        '1, '0, 32'h0};
      v[8]  = '{'0, '0, '0, 32'h0,  32'h0,        '0, '0, '0, 32'h0,        '0, '0, '0, 32'h0,        '0, 32'h0,        '0, '1, 32'h12345678};
      v[9]  = '{'0, '0, '0, 32'h0,  32'h0,        '0, '0, '0, 32'h0,        '0, '0, '0, 32'h0,        '0, 32'h0,        '0, '0, 32'h12345678};
      v[10] = '{'1, '0, '0, 32'h10, 32'h0,        '1, '0, 10'd7, 32'h0,     '1, '0, 10'd7, 32'h0,     '0, 32'h0,        '1, '0, 32'h12345678};
      v[11] = '{'1, '1, '0, 32'h10, 32'h0,        '1, '0, 10'd7, 32'h0,     '1, '0, 10'd4, 32'h0,     '0, 32'h0,        '0, '1, 32'h12345678};
      v[12] = '{'1, '1, '0, 32'h10, 32'h0,        '1, '0, 10'd7, 32'h0,     '1, '0, 10'd7, 32'h0,     '1, 32'hDEADBEEF, '1, '0, 32'h12345678};
      v[13] = '{'0, '0, '0, 32'h0,  32'h0,        '0, '0, '0, 32'h0,        '0, '0, '0, 32'h0,        '0, 32'h0,        '0, '1, 32'h12345678};
      nRST = 1'b0;
      sa(0, 0, 0, 0, 0);
      sd(0, 0, 0, 0);
      repeat (2) @(posedge CLK);
      for (int i = 0; i < 14; i++) begin
         step;
         nRST = 1'b1;
         sa(v[i].psel, v[i].pen, v[i].pwr, v[i].paddr, v[i].pwdata);
         sd(v[i].dreq, v[i].dwen, v[i].daddr, v[i].dwdata);
         @(negedge CLK);
         chk($sformatf("vec%0d", i),
             {ram_en, ram_wen, ram_addr, ram_wdata, PREADY, PRDATA, dma_gnt, dma_rvalid, dma_rdata},
             {v[i].en, v[i].wen, v[i].addr, v[i].wdata, v[i].rdy, v[i].prd, v[i].gnt, v[i].rv, v[i].drd});
      end
      step; sa(1, 0, 0, 32'h10, 0); sd(0, 0, 0, 0);
      step; sa(1, 1, 0, 32'h10, 0);
      @(negedge CLK); chk("rst pre grant", {ram_en, ram_addr}, {1'b1, 10'd4});
      step; nRST = 1'b0; sd(1, 0, 10'd7, 0);
      @(negedge CLK); chk("rst no strobe", {ram_en, dma_gnt}, 2'b00);
      step;
      @(negedge CLK); chk("rst state", {PREADY, dma_rvalid, ram_en}, 3'b000);
      step; nRST = 1'b1;
      @(negedge CLK); chk("tie after rst", {ram_en, ram_addr, dma_gnt}, {1'b1, 10'd4, 1'b0});
      step;
      @(negedge CLK); chk("tie resp", {PREADY, PRDATA, dma_gnt, ram_addr}, {1'b1, 32'hDEADBEEF, 1'b1, 10'd7});
      step; sa(0, 0, 0, 0, 0); sd(0, 0, 0, 0);
      @(negedge CLK); chk("tie dma data", {dma_rvalid, dma_rdata}, {1'b1, 32'h12345678});
      step; sd(1, 1, 10'd0, 32'hA5A5A5A5);
      @(negedge CLK); chk("dma wr0", {dma_gnt, ram_wen, ram_addr}, {2'b11, 10'd0});
      step; sd(0, 0, 0, 0); sa(1, 0, 0, 32'h1002, 0);
      step; sa(1, 1, 0, 32'h1002, 0);
      @(negedge CLK);
`ifdef APB_RAM_ERR_EN
      chk("err no strobe", {ram_en, PREADY}, 2'b00);
`else
      chk("alias grant", {ram_en, ram_addr, PREADY}, {1'b1, 10'd0, 1'b0});
`endif
      step;
      @(negedge CLK);
`ifdef APB_RAM_ERR_EN
      chk("err resp", {PREADY, PSLVERR, PRDATA, ram_en}, {2'b11, 32'h0, 1'b0});
`else
      chk("alias resp", {PREADY, PSLVERR, PRDATA}, {2'b10, 32'hA5A5A5A5});
`endif
      step; sa(0, 0, 0, 0, 0); nRST = 1'b0;
      repeat (2) @(posedge CLK);
      #1; nRST = 1'b1;
      ml = 1'b1; mr = 1'b0; mw = 1'b0; mdv = 1'b0; ddrop = 1'b0; mrx = 0; mdx = 0;
      ast = 0; ac = 0; dw = 0;
      for (int c = 0; c < 3000; c++) begin
         step;
         if (ddrop) begin dma_req = 1'b0; ddrop = 1'b0; end
         if (ast == 0) begin
            if ($urandom_range(2) == 0) begin
               sa(1, 0, 1'($urandom), $urandom_range(47, 32) << 2, $urandom);
               ast = 1;
            end else sa(0, 0, 0, 0, 0);
         end else if (ast == 1) begin
            PENABLE = 1'b1; ast = 2; ac = 0;
         end
         if (!dma_req && $urandom_range(1) == 1) begin
            sd(1, 1'($urandom), 10'($urandom_range(47, 32)), $urandom);
            dw = 0;
         end
         @(negedge CLK);
         aw = PADDR[11:2];
         awin = PSEL & PENABLE & !mr & (!dma_req | ml);
         dwin = dma_req & !awin;
         chk("rand gnt", {ram_en, dma_gnt}, {awin | dwin, dwin});
         chk("rand ready", PREADY, mr);
         if (awin) chk("rand apb pins", {ram_wen, ram_addr, ram_wdata}, {PWRITE, aw, PWDATA});
         if (dwin) chk("rand dma pins", {ram_wen, ram_addr, ram_wdata}, {dma_wen, dma_addr, dma_wdata});
         if (mr && !mw) chk("rand prdata", PRDATA, mrx);
         if (mdv) chk("rand dma data", {dma_rvalid, dma_rdata}, {1'b1, mdx});
         else chk("rand dma idle", dma_rvalid, 1'b0);
         if (ast == 2) ac++;
         if (mr) begin chk("apb latency", ac > 3, 1'b0); ast = 0; end
         if (dma_req && !dwin) dw++;
         if (dwin) begin chk("dma wait", dw > 1, 1'b0); ddrop = 1'b1; end
         mdv = dwin & !dma_wen;
         if (mdv) mdx = sh[dma_addr];
         if (awin) begin
            mw = PWRITE;
            if (PWRITE) sh[aw] = PWDATA;
            else mrx = sh[aw];
         end
         if (dwin && dma_wen) sh[dma_addr] = dma_wdata;
         if (awin || dwin) ml = dwin;
         mr = awin;
      end
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
